// File: rtl/sm83_bus_pkg.sv
// Shared definitions for the sm83 memory-bus glue: DMA state encoding,
// fixed register/region addresses and the echo-RAM source folding rule.
package sm83_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] HI_BASE      = 16'hFF00;
  localparam logic [7:0]  OAM_LEN      = 8'd160;
  localparam logic [7:0]  OAM_LAST     = OAM_LEN - 8'd1;
  localparam logic [7:0]  OPEN_BUS     = 8'hFF;
  localparam logic [7:0]  ECHO_PAGE    = 8'hE0;

  // Pages 0xE0..0xFF alias work RAM 0x20 pages lower.
  function automatic logic [7:0] dma_src_page(input logic [7:0] src);
    return (src >= ECHO_PAGE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine and single-port bus arbiter between the sm83 core and main
// memory; copies 160 bytes into OAM while fencing the CPU to 0xFF00-0xFFFF.
module oam_dma_ctrl
  import sm83_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic [7:0]  cpu_d_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_d_out,
  output logic        mem_write,
  input  logic [7:0]  mem_d_in,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  dma_state_t state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic [7:0] pend_idx_q, pend_idx_d;
  logic       dma_active_q, dma_active_d;

  logic reg_hit;
  logic cpu_hi;
  logic dma_busy;
  logic dma_rd;

  always_comb begin
    reg_hit  = (cpu_addr == DMA_REG_ADDR);
    cpu_hi   = (cpu_addr >= HI_BASE);
    dma_busy = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
    // High-region CPU accesses win the port; the DMA read simply waits.
    dma_rd   = (state_q == ST_ACTIVE) && !cpu_hi;
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_d_out = cpu_d_out;
    mem_write = cpu_write && !reg_hit;
    cpu_d_in  = mem_d_in;
    if (dma_rd) begin
      mem_addr  = {dma_src_page(src_q), idx_q};
      mem_write = 1'b0;
    end else if (dma_busy && !cpu_hi) begin
      mem_write = 1'b0;
    end
    if (reg_hit) begin
      cpu_d_in = src_q;
    end else if (dma_busy && !cpu_hi) begin
      cpu_d_in = OPEN_BUS;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    pend_vld_d  = 1'b0;
    pend_byte_d = pend_byte_q;
    pend_idx_d  = pend_idx_q;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_START: state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (dma_rd) begin
          pend_vld_d  = 1'b1;
          pend_byte_d = mem_d_in;
          pend_idx_d  = idx_q;
          idx_d       = idx_q + 8'd1;
          if (idx_q == OAM_LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A register write restarts from any state; a pending OAM write still
    // drains this cycle because the outputs come from the pend flops.
    if (cpu_write && reg_hit) begin
      src_d   = cpu_d_out;
      idx_d   = 8'd0;
      state_d = ST_START;
    end
    dma_active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      src_q        <= 8'hFF;
      idx_q        <= 8'd0;
      pend_vld_q   <= 1'b0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      pend_vld_q   <= pend_vld_d;
      dma_active_q <= dma_active_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_byte_q <= pend_byte_d;
    pend_idx_q  <= pend_idx_d;
  end

  assign oam_we     = pend_vld_q;
  assign oam_addr   = pend_idx_q;
  assign oam_wdata  = pend_byte_q;
  assign dma_active = dma_active_q;

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sits between the sm83 core and the main memory bus. Owns the OAM DMA register (0xFF46) and arbitrates the single memory port between CPU accesses and the OAM DMA engine. While DMA runs, the block copies 160 bytes from `{src,8'h00}` to OAM over a dedicated OAM write port and restricts the CPU to the 0xFF00–0xFFFF region.

## Interface
- `OAM_LEN`, 160, bytes copied per DMA
- `DMA_REG`, 16'hFF46, DMA register address
- `HI_BASE`, 16'hFF00, lowest CPU address still reachable during DMA

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_addr`  in  16  CPU address
- `cpu_d_out`  in  8  CPU write data
- `cpu_write`  in  1  CPU write strobe
- `cpu_d_in`  out  8  read data to CPU
- `mem_addr`  out  16  main memory address
- `mem_d_out`  out  8  main memory write data
- `mem_write`  out  1  main memory write strobe
- `mem_d_in`  in  8  main memory read data, valid at the rising edge ending the cycle `mem_addr` was driven
- `oam_addr`  out  8  OAM write index
- `oam_wdata`  out  8  OAM write data
- `oam_we`  out  1  OAM write strobe
- `dma_active`  out  1  DMA in progress

## Operation
- States: IDLE, START, ACTIVE, DRAIN. Registers: `src` (8b), `idx` (8b), `pend` (valid + byte + index).
- CPU write to `DMA_REG` (any state): `src <= cpu_d_out`, `idx <= 0`, state → START. Not forwarded to memory (`mem_write`=0). CPU read of `DMA_REG` returns `src`.
- IDLE, START: CPU owns the bus. `mem_addr/mem_d_out/mem_write` follow CPU; `cpu_d_in = mem_d_in`.
- ACTIVE: each cycle DMA reads `mem_addr = {src', idx}`, where `src' = src - 8'h20` if `src >= 8'hE0`, else `src`; `mem_write`=0. At cycle end `pend <= {1, mem_d_in, idx}`, `idx++`. After `idx == OAM_LEN-1` is read → DRAIN.
- CPU priority: in ACTIVE, if `cpu_addr >= HI_BASE`, the CPU owns the bus that cycle; DMA read stalls (`idx` holds).
- Blocked CPU: in ACTIVE/DRAIN with `cpu_addr < HI_BASE`, reads return 8'hFF, writes are dropped.
- OAM port: whenever `pend` is valid, `oam_we`=1, `oam_addr`=pend index, `oam_wdata`=pend byte, then `pend` clears (unless reloaded). The OAM write is independent of bus ownership.
- DRAIN: issues the final OAM write, then → IDLE.
- `dma_active` = 1 in START, ACTIVE, DRAIN.
- Restart in ACTIVE/DRAIN: an outstanding `pend` write still completes in the restart cycle. The copy then restarts from index 0.

## Timing
- Reset values: state IDLE, `src` 8'hFF, `idx` 0, `pend` invalid, `oam_we` 0, `dma_active` 0. Bus outputs are combinational and follow the CPU.
- Reset mid-DMA aborts immediately; no further OAM writes.
- DMA register write sampled at the edge ending cycle T:
  - START in T+1.
  - Reads idx 0..159 in T+2..T+161.
  - OAM writes idx 0..159 in T+3..T+162.
  - `dma_active` high T+1..T+162, with no stalls.
- Each CPU-priority stall cycle adds one cycle to completion.
- All bus muxing is combinational. Latency is zero added cycles for CPU accesses.

## Structure
- Shared package `sm83_bus_pkg`: state enum `dma_state_t`, constants `DMA_REG_ADDR`, `HI_BASE`, `OAM_LEN`, `OPEN_BUS` (8'hFF).
- Single module. No sub-module is warranted.

## Test plan
- Basic copy: preload `mem[16'hC000+i] = i ^ 8'h5A`, CPU writes 8'hC0 to 0xFF46 at T → 160 `oam_we` pulses T+3..T+162, `oam_addr` 0..159, data `i^8'h5A`; `dma_active` T+1..T+162.
- Blocked CPU: during ACTIVE, CPU reads 0x0100 → `cpu_d_in`=8'hFF and `mem_addr`=DMA source. CPU writes 0xC123 → `mem_write` stays 0 and memory is unchanged.
- Priority stall: CPU reads 0xFF80 while idx=40 is next → CPU gets `mem_d_in` that cycle. idx 40 is read the following cycle, and completion slips one cycle to T+163.
- Restart: write 8'hD0 to 0xFF46 after idx 80 has been written → pending write completes. 160 fresh writes from 0xD000 start three cycles later, and `dma_active` stays high throughout.
- Echo/readback: write 8'hE1 → reads come from 0xC100..0xC19F, and a CPU read of 0xFF46 returns 8'hE1.
- Reset: assert `rst` at idx 50 → same cycle `oam_we`=0 and `dma_active`=0. `src` reads back 8'hFF.
